// File: rtl/ysyx_22050854_dsram_rd_arbiter.sv
// ysyx_22050854_dsram_rd_arbiter
// Read-channel arbiter that shares one data SRAM slave between two masters,
// m0 (IFU) and m1 (LSU). Only one slave transaction is outstanding at a time.
// On a tie, the master that was not granted last wins (round-robin).
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   mX_araddr/arvalid/arready   : per-master read-address channel
//   mX_rdata/rvalid/rready      : per-master read-data channel
//   s_araddr/arvalid/arready    : address channel to the SRAM
//   s_rdata/rresp/rvalid/rready : data channel from the SRAM
//   owner                       : current or last grantee (0 = m0, 1 = m1)
//   busy                        : a transaction is outstanding
//   timeout                     : one-cycle pulse when the watchdog aborts
module ysyx_22050854_dsram_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [63:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [63:0] m1_rdata,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [63:0] s_rdata,
  input  logic        s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic        owner,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        timeout_q, timeout_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wd_q, wd_d;

  logic       pick1;
  logic       grant;
  logic       beat;
  logic       own_rready;
  logic [7:0] wd_inc;
  logic       abort;
  logic       data_ok;

  always_comb begin
    // m1 wins if it is the only requester, or on a tie when m0 was granted last.
    pick1      = m1_arvalid & (~m0_arvalid | ~last_q);
    grant      = (state_q == IDLE) & (m0_arvalid | m1_arvalid);
    beat       = s_rvalid & s_rresp;
    own_rready = owner_q ? m1_rready : m0_rready;
    wd_inc     = wd_q + 8'd1;
    // Abort on the edge where the watchdog reaches 255; this wins over any
    // handshake completing in the same cycle.
    abort      = (state_q != IDLE) & (wd_inc == 8'hFF);

    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ADDR;
          owner_d = pick1;
          last_d  = pick1;
          addr_d  = pick1 ? m1_araddr : m0_araddr;
          wd_d    = '0;
        end
      end
      ADDR: begin
        wd_d = wd_inc;
        if (abort) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (s_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        wd_d = wd_inc;
        if (abort) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (beat & own_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Handshake outputs are masked by rst so a reset cycle never grants,
  // issues or delivers anything.
  always_comb begin
    data_ok    = ~rst & (state_q == DATA) & ~abort;
    m0_arready = ~rst & grant & ~pick1;
    m1_arready = ~rst & grant & pick1;
    s_arvalid  = ~rst & (state_q == ADDR);
    s_araddr   = addr_q;
    m0_rvalid  = data_ok & ~owner_q & beat;
    m1_rvalid  = data_ok & owner_q & beat;
    s_rready   = data_ok & own_rready;
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    owner      = owner_q;
    busy       = (state_q != IDLE);
    timeout    = timeout_q;
  end

endmodule

// File: tb/tb_ysyx_22050854_dsram_rd_arbiter.sv
module tb_ysyx_22050854_dsram_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, s_araddr;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [63:0] m0_rdata, m1_rdata, s_rdata;
  logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic        s_arvalid, s_arready, s_rresp, s_rvalid, s_rready;
  logic        owner, busy, timeout;

  ysyx_22050854_dsram_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ar0, ar1, sav;
    logic [31:0] saddr;
    logic        rv0, rv1, srdy, own, bsy, to;
  } outs_t;

  typedef struct packed {
    logic        rst, m0v;
    logic [31:0] m0a;
    logic        m1v;
    logic [31:0] m1a;
    logic        m0rr, m1rr, sar, srv, srr;
    logic [63:0] sd;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] A2 = 32'h8000_1000;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        tbl[$];

  function automatic outs_t o(input logic ar0, ar1, sav, input logic [31:0] sa,
                              input logic rv0, rv1, srdy, own, bsy, to);
    return outs_t'{ar0, ar1, sav, sa, rv0, rv1, srdy, own, bsy, to};
  endfunction

  function automatic vec_t v(input logic m0v, input logic [31:0] m0a,
                             input logic m1v, input logic [31:0] m1a,
                             input logic m0rr, m1rr, sar, srv, srr,
                             input logic [63:0] sd, input outs_t exp);
    return vec_t'{1'b0, m0v, m0a, m1v, m1a, m0rr, m1rr, sar, srv, srr, sd, exp};
  endfunction

  function automatic outs_t get_outs();
    return outs_t'{m0_arready, m1_arready, s_arvalid, s_araddr,
                   m0_rvalid, m1_rvalid, s_rready, owner, busy, timeout};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    rst        = t.rst;
    m0_arvalid = t.m0v;  m0_araddr = t.m0a;
    m1_arvalid = t.m1v;  m1_araddr = t.m1a;
    m0_rready  = t.m0rr; m1_rready = t.m1rr;
    s_arready  = t.sar;  s_rvalid  = t.srv;
    s_rresp    = t.srr;  s_rdata   = t.sd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int unsigned n;
  logic        found;

  initial begin
    // Row 0: reset state. Tie rows: grants m0,m1,m0,m1 with own data.
    // Then a lone m1 request right after an m1 grant, zero-wait slave.
    tbl.push_back(v(0, 0,  0, 0,  0, 0, 0, 0, 0, 64'h0, o(0,0,0,32'h0,0,0,0,0,0,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(1,0,0,32'h0,0,0,0,0,0,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(0,0,1,A0,0,0,0,0,1,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 0, 1, 1, 1, D0,    o(0,0,0,A0,1,0,1,0,1,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(0,1,0,A0,0,0,0,0,0,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(0,0,1,A1,0,0,0,1,1,0)));
    tbl.push_back(v(1, A0, 1, A1, 0, 1, 1, 1, 1, D1,    o(0,0,0,A1,0,1,1,1,1,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(1,0,0,A1,0,0,0,1,0,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(0,0,1,A0,0,0,0,0,1,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 1, 1, D0,    o(0,0,0,A0,1,0,1,0,1,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(0,1,0,A0,0,0,0,0,0,0)));
    tbl.push_back(v(1, A0, 1, A1, 1, 1, 1, 0, 0, 64'h0, o(0,0,1,A1,0,0,0,1,1,0)));
    tbl.push_back(v(0, A0, 0, A1, 1, 1, 1, 1, 1, D1,    o(0,0,0,A1,0,1,1,1,1,0)));
    tbl.push_back(v(0, 0,  1, A2, 1, 1, 1, 0, 0, 64'h0, o(0,1,0,A1,0,0,0,1,0,0)));
    tbl.push_back(v(0, 0,  0, A2, 1, 1, 1, 0, 0, 64'h0, o(0,0,1,A2,0,0,0,1,1,0)));
    tbl.push_back(v(0, 0,  0, A2, 1, 1, 1, 1, 1, D2,    o(0,0,0,A2,0,1,1,1,1,0)));
    tbl.push_back(v(0, 0,  0, 0,  1, 1, 1, 0, 0, 64'h0, o(0,0,0,A2,0,0,0,1,0,0)));

    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, o(0,0,0,32'h0,0,0,0,0,0,0)));
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 64'(get_outs()), 64'(tbl[i].exp));
      chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, tbl[i].sd);
      chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, tbl[i].sd);
      next_cycle();
    end

    // Back-pressure: m0 wins the tie (m1 granted last), then stalls rready.
    m0_arvalid = 1; m0_araddr = A0; m1_arvalid = 1; m1_araddr = A1;
    m0_rready = 1; m1_rready = 1; s_arready = 1; s_rvalid = 0; s_rresp = 0;
    @(negedge clk);
    chk("bp_grant_m0", m0_arready, 1'b1);
    chk("bp_m1_stalled", m1_arready, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("bp_addr", s_arvalid, 1'b1);
    next_cycle();
    s_rvalid = 1; s_rresp = 1; s_rdata = D0; m0_rready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_busy", k), busy, 1'b1);
      chk($sformatf("bp_hold%0d_srready", k), s_rready, 1'b0);
      chk($sformatf("bp_hold%0d_m1_arready", k), m1_arready, 1'b0);
      chk($sformatf("bp_hold%0d_m0_rvalid", k), m0_rvalid, 1'b1);
      next_cycle();
    end
    m0_rready = 1;
    @(negedge clk);
    chk("bp_release_srready", s_rready, 1'b1);
    chk("bp_release_rvalid", m0_rvalid, 1'b1);
    next_cycle();
    s_rvalid = 0; s_rresp = 0; m0_arvalid = 0;
    @(negedge clk);
    chk("bp_then_m1_granted", m1_arready, 1'b1);
    chk("bp_idle_busy", busy, 1'b0);

    // Stale-valid slave: rvalid high, rresp low, then rresp rises.
    next_cycle();
    m1_arvalid = 0;
    @(negedge clk);
    chk("sv_addr", s_araddr, A1);
    chk("sv_owner", owner, 1'b1);
    next_cycle();
    s_rvalid = 1; s_rresp = 0; s_rdata = D2; m1_rready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sv_stale%0d_m1_rvalid", k), m1_rvalid, 1'b0);
      chk($sformatf("sv_stale%0d_m0_rvalid", k), m0_rvalid, 1'b0);
      chk($sformatf("sv_stale%0d_busy", k), busy, 1'b1);
      next_cycle();
    end
    s_rresp = 1; s_rdata = D1;
    @(negedge clk);
    chk("sv_beat_rvalid", m1_rvalid, 1'b1);
    chk("sv_beat_rdata", m1_rdata, D1);
    next_cycle();

    // Watchdog: slave never accepts the address.
    s_rvalid = 0; s_rresp = 0; s_arready = 0; m0_arvalid = 1; m0_araddr = A0;
    @(negedge clk);
    chk("wd_idle", busy, 1'b0);
    chk("wd_grant_m0", m0_arready, 1'b1);
    n = 0;
    found = 0;
    while (!found && n < 300) begin
      next_cycle();
      n++;
      if (n == 1) begin
        m0_arvalid = 0; m1_arvalid = 1; m1_araddr = A1;
      end
      @(negedge clk);
      if (n == 1) begin
        chk("wd_m1_stalled", m1_arready, 1'b0);
        chk("wd_addr_valid", s_arvalid, 1'b1);
      end
      if (timeout) found = 1;
    end
    // Grant edge, then 255 further edges until the counter reaches 255.
    chk("wd_latency", 64'(n), 64'd256);
    chk("wd_busy_cleared", busy, 1'b0);
    chk("wd_no_rvalid", m0_rvalid, 1'b0);
    chk("wd_m1_granted", m1_arready, 1'b1);
    next_cycle();
    m1_arvalid = 0; s_arready = 1;
    @(negedge clk);
    chk("wd_pulse_one_cycle", timeout, 1'b0);
    chk("wd_m1_addr", s_arvalid, 1'b1);
    next_cycle();

    // Reset in DATA with a beat pending.
    s_rvalid = 1; s_rresp = 1; m1_rready = 0; rst = 1;
    @(negedge clk);
    chk("rst_no_rvalid", m1_rvalid, 1'b0);
    chk("rst_no_srready", s_rready, 1'b0);
    next_cycle();
    rst = 0; s_rvalid = 0; s_rresp = 0; s_arready = 0;
    @(negedge clk);
    chk("rst_outs_clear", 64'(get_outs()), 64'(o(0,0,0,32'h0,0,0,0,0,0,0)));
    next_cycle();
    m0_arvalid = 1; m1_arvalid = 1;
    @(negedge clk);
    chk("rst_tie_m0", m0_arready, 1'b1);
    chk("rst_tie_not_m1", m1_arready, 1'b0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
